color_priority_sched: RTL and testbench

//   Per-pixel color scheduler in front of the 7-bit Atari color lookup.
//   - Holds the TIA color/priority registers (COLUP0, COLUP1, COLUPF, COLUBK, CTRLPF).
//   - Arbitrates the object hit flags of each pixel by the TIA priority rules.
//   - Emits one 7-bit color index per pixel through a 1-stage valid/ready pipeline,

---
 rtl/color_priority_sched.sv | 112 +++++++++++
 tb/tb_color_priority_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/color_priority_sched.sv
// Per-pixel color scheduler: holds the TIA color/priority registers,
// arbitrates each pixel's object hit flags by TIA priority rules and
// emits one 7-bit color index per pixel through a single output register
// with a valid/ready handshake.
module color_priority_sched #(
  parameter int HALF_X = 80,
  parameter int XW     = 8
) (
  input  logic          clk,
  input  logic          reset,      // asynchronous, active-low
  input  logic          wr_en,
  input  logic [2:0]    wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] pixel_x,
  input  logic          blank,
  input  logic          p0,
  input  logic          m0,
  input  logic          p1,
  input  logic          m1,
  input  logic          pf,
  input  logic          bl,
  output logic [6:0]    color,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam logic [XW-1:0] HALF_X_V = XW'(HALF_X);

  localparam logic [2:0] ADDR_COLUP0 = 3'd0;
  localparam logic [2:0] ADDR_COLUP1 = 3'd1;
  localparam logic [2:0] ADDR_COLUPF = 3'd2;
  localparam logic [2:0] ADDR_COLUBK = 3'd3;
  localparam logic [2:0] ADDR_CTRLPF = 3'd4;

  logic [6:0] colup0, colup1, colupf, colubk;
  logic       score, pfp;
  logic [6:0] pfc;
  logic [6:0] next_color;
  logic       accept;

  // The output register may be refilled whenever it is empty or draining.
  assign in_ready = out_ready | ~out_valid;
  assign accept   = in_valid & in_ready;

  // Register file writes; a pixel accepted on the same edge still sees the old values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, which is what gives writes their "old value
      // for the same-cycle pixel" behaviour.
      colup0 <= '0;
      colup1 <= '0;
      colupf <= '0;
      colubk <= '0;
      score  <= 1'b0;
      pfp    <= 1'b0;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_COLUP0: colup0 <= wr_data[7:1];
        ADDR_COLUP1: colup1 <= wr_data[7:1];
        ADDR_COLUPF: colupf <= wr_data[7:1];
        ADDR_COLUBK: colubk <= wr_data[7:1];
        ADDR_CTRLPF: begin
          score <= wr_data[1];
          pfp   <= wr_data[2];
        end
        default: ;  // addresses 5-7 are ignored
      endcase
    end
  end

  // Priority arbitration of the hit flags for the pixel being offered.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the block can leave it unassigned and infer a latch.
    pfc        = colupf;
    next_color = colubk;
    // Score mode colors the playfield with the player color of each half;
    // playfield priority overrides score mode.
    if (score && !pfp) begin
      pfc = (pixel_x < HALF_X_V) ? colup0 : colup1;
    end
    if (blank) begin
      next_color = 7'd0;
    end else if (pfp) begin
      if (pf || bl)      next_color = colupf;
      else if (p0 || m0) next_color = colup0;
      else if (p1 || m1) next_color = colup1;
    end else begin
      if (p0 || m0)      next_color = colup0;
      else if (p1 || m1) next_color = colup1;
      else if (pf)       next_color = pfc;
      else if (bl)       next_color = colupf;
    end
  end

  // Single-entry output stage: load on accept, drop valid once drained.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      color     <= 7'd0;
      out_valid <= 1'b0;
    end else if (accept) begin
      color     <= next_color;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_color_priority_sched.sv
// Self-checking bench for color_priority_sched: directed scenarios plus
// randomized traffic, compared against a behavioural model of the register
// file, the priority rules and an in-order delivery scoreboard.
module tb_color_priority_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] pixel_x;
  logic       blank, p0, m0, p1, m1, pf, bl;
  logic [6:0] color;
  logic       out_valid;
  logic       out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: colors indexed COLUP0, COLUP1, COLUPF, COLUBK.
  logic [6:0] m_c [4];
  bit         m_score, m_pfp;
  logic [6:0] exp_q [$];   // accepted pixels not yet delivered
  bit         accepted;

  // Hit vector layout: {blank, p0, m0, p1, m1, pf, bl}
  localparam logic [6:0] H_NONE  = 7'b0000000;
  localparam logic [6:0] H_BLANK = 7'b1000000;
  localparam logic [6:0] H_P0    = 7'b0100000;
  localparam logic [6:0] H_P1    = 7'b0001000;
  localparam logic [6:0] H_PF    = 7'b0000010;
  localparam logic [6:0] H_BL    = 7'b0000001;

  color_priority_sched #(.HALF_X(80), .XW(8)) dut (
    .clk(clk), .reset(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .pixel_x(pixel_x),
    .blank(blank), .p0(p0), .m0(m0), .p1(p1), .m1(m1), .pf(pf), .bl(bl),
    .color(color), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // The color the TIA priority rules give for a pixel under the model registers.
  function automatic logic [6:0] ref_color(input logic [7:0] x, input logic [6:0] h);
    logic [6:0] layer_color [3];
    bit         layer_hit   [3];
    logic [6:0] pf_color;
    if (h[6]) return 7'd0;
    pf_color = (m_score && !m_pfp) ? ((x < 8'd80) ? m_c[0] : m_c[1]) : m_c[2];
    if (m_pfp) begin
      layer_hit[0] = h[1] | h[0]; layer_color[0] = m_c[2];
      layer_hit[1] = h[5] | h[4]; layer_color[1] = m_c[0];
      layer_hit[2] = h[3] | h[2]; layer_color[2] = m_c[1];
    end else begin
      layer_hit[0] = h[5] | h[4]; layer_color[0] = m_c[0];
      layer_hit[1] = h[3] | h[2]; layer_color[1] = m_c[1];
      layer_hit[2] = h[1];        layer_color[2] = pf_color;
      if (!layer_hit[2] && h[0]) begin
        layer_hit[2] = 1'b1; layer_color[2] = m_c[2];
      end
    end
    for (int i = 0; i < 3; i++) if (layer_hit[i]) return layer_color[i];
    return m_c[3];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_c[i] = 7'd0;
    m_score = 0;
    m_pfp   = 0;
    exp_q.delete();
  endtask

  // One clock cycle, entered and left at a falling edge: drive, check, advance model.
  task automatic step(input bit we, input logic [2:0] wa, input logic [7:0] wd,
                      input bit iv, input logic [7:0] x, input logic [6:0] h,
                      input bit ordy);
    logic [6:0] pix;
    wr_en = we; wr_addr = wa; wr_data = wd;
    in_valid = iv; pixel_x = x;
    {blank, p0, m0, p1, m1, pf, bl} = h;
    out_ready = ordy;
    #1;
    check("in_ready", in_ready, ordy || exp_q.size() == 0);
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("color", color, exp_q[0]);
    pix = ref_color(x, h);
    @(posedge clk);
    accepted = iv && (ordy || exp_q.size() == 0);
    if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
    if (accepted) exp_q.push_back(pix);
    if (we) begin
      if (wa < 3'd4) m_c[wa] = wd[7:1];
      else if (wa == 3'd4) begin
        m_score = wd[1];
        m_pfp   = wd[2];
      end
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    step(1'b1, a, d, 1'b0, 8'd0, H_NONE, 1'b1);
  endtask

  // Offer a pixel with a draining sink, then check the delivered color literally.
  task automatic pix_expect(input string tag, input logic [7:0] x, input logic [6:0] h,
                            input logic [6:0] exp);
    step(1'b0, 3'd0, 8'd0, 1'b1, x, h, 1'b1);
    #1;
    check(tag, color, exp);
    check({tag, "_v"}, out_valid, 1'b1);
  endtask

  initial begin
    logic [6:0] hold_val;
    rst_n = 1'b0;
    wr_en = 0; wr_addr = 0; wr_data = 0; in_valid = 0; pixel_x = 0;
    {blank, p0, m0, p1, m1, pf, bl} = H_NONE;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_color", color, 7'd0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // 1. all-clear pixel after reset
    pix_expect("t1_clear", 8'd20, H_NONE, 7'h00);

    // 2. player 0 and background colors
    wr(3'd3, 8'h1C);
    wr(3'd0, 8'h44);
    pix_expect("t2_p0", 8'd20, H_P0, 7'h22);
    pix_expect("t2_bk", 8'd20, H_NONE, 7'h0E);

    // 3. p1 over pf, then playfield priority
    wr(3'd2, 8'h86);
    wr(3'd1, 8'hC8);
    pix_expect("t3_pfp0", 8'd30, H_P1 | H_PF, 7'h64);
    wr(3'd4, 8'h04);
    pix_expect("t3_pfp1", 8'd30, H_P1 | H_PF, 7'h43);

    // 4. score mode halves and ball color
    wr(3'd4, 8'h02);
    pix_expect("t4_x79", 8'd79, H_PF, 7'h22);
    pix_expect("t4_x80", 8'd80, H_PF, 7'h64);
    pix_expect("t4_x200", 8'd200, H_PF, 7'h64);
    pix_expect("t4_bl", 8'd10, H_BL, 7'h43);
    pix_expect("t4_pfbl", 8'd10, H_PF | H_BL, 7'h22);

    // 5. four pixels with the sink stalled three cycles mid-stream
    step(1'b0, 3'd0, 8'd0, 1'b1, 8'd5, H_P0, 1'b1);
    step(1'b0, 3'd0, 8'd0, 1'b1, 8'd90, H_PF, 1'b0);
    hold_val = color;
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 3'd0, 8'd0, 1'b1, 8'd90, H_PF, 1'b0);
      check("t5_hold", color, hold_val);
      check("t5_stall_ready", in_ready, 1'b0);
    end
    for (int k = 0; k < 8 && !accepted; k++)
      step(1'b0, 3'd0, 8'd0, 1'b1, 8'd90, H_PF, 1'b1);
    step(1'b0, 3'd0, 8'd0, 1'b1, 8'd3, H_NONE, 1'b1);
    step(1'b0, 3'd0, 8'd0, 1'b1, 8'd4, H_BL, 1'b1);
    step(1'b0, 3'd0, 8'd0, 1'b0, 8'd0, H_NONE, 1'b1);
    step(1'b0, 3'd0, 8'd0, 1'b0, 8'd0, H_NONE, 1'b1);
    check("t5_drained", out_valid, 1'b0);

    // 6. same-cycle write uses the old value; blank overrides hits
    step(1'b1, 3'd3, 8'h50, 1'b1, 8'd40, H_NONE, 1'b1);
    #1 check("t6_old_bk", color, 7'h0E);
    pix_expect("t6_new_bk", 8'd40, H_NONE, 7'h28);
    pix_expect("t6_blank", 8'd40, H_BLANK | H_P0, 7'h00);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [2:0] ra;
      ra = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 3) == 0), ra, 8'($urandom),
           ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 199)),
           {($urandom_range(0, 7) == 0), 6'($urandom)},
           ($urandom_range(0, 3) != 0));
    end

    // reset with a pixel in flight: outputs clear without a clock edge
    step(1'b0, 3'd0, 8'd0, 1'b1, 8'd40, H_P0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", out_valid, 1'b0);
    check("t6_rst_color", color, 7'd0);
    check("t6_rst_in_ready", in_ready, 1'b1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    pix_expect("t6_after_rst", 8'd40, H_P0, 7'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
